dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache controller sitting in the MEM stage between the CPU datapath and off-chip data memory.
- It is the producer of the memory-stall signal that the MEM/WB pipeline register and the upstream pipeline registers consume. It holds that stall while a miss is serviced.
- It also owns the 256-bit line handshake to data memory.

---
 rtl/dcache_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Owns the pipeline memory stall and the line-wide handshake to data memory.
module dcache_ctrl #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned BYTE_SH   = $clog2(WORD_BITS / 8);
  localparam int unsigned WORD_SH   = $clog2(WORD_BITS);
  localparam int unsigned OFF_W     = $clog2(LINE_BITS / 8);
  localparam int unsigned WSEL_W    = $clog2(LINE_BITS / WORD_BITS);
  localparam int unsigned BIT_W     = $clog2(LINE_BITS);
  localparam int unsigned IDX_W     = $clog2(LINES);
  localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WB, ALLOC, FILL} state_t;

  state_t               state_q, state_d;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    word;
  logic [BIT_W-1:0]     word_lsb;
  logic                 hit, fill_we, store_we;
  logic [ADDR_W-1:0]    victim_addr, fill_addr;
  logic                 en_d, wr_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [LINE_BITS-1:0] line_d;
  logic                 addr_unused;

  // Address decode; byte offset within the word is don't-care.
  assign req_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign word        = cpu_addr_i[BYTE_SH +: WSEL_W];
  assign word_lsb    = BIT_W'(word) << WORD_SH;
  assign addr_unused = ^cpu_addr_i[BYTE_SH-1:0];

  assign victim_addr = {tag_q[idx], idx, {OFF_W{1'b0}}};
  assign fill_addr   = {req_tag, idx, {OFF_W{1'b0}}};

  assign hit         = cpu_req_i && valid_q[idx] && (tag_q[idx] == req_tag);
  assign cpu_stall_o = cpu_req_i && ((state_q != IDLE) || !hit);
  assign cpu_data_o  = (hit && !cpu_we_i) ? data_q[idx][word_lsb +: WORD_BITS] : '0;

  // Array writes are suppressed under reset so an abandoned fill never lands.
  assign fill_we  = (state_q == ALLOC) && mem_ack_i && !rst_i;
  assign store_we = (state_q == IDLE) && hit && cpu_we_i && !rst_i;

  // Next state and next memory-request outputs; requests are held until acked.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    line_d  = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          en_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d = WB;
            wr_d    = 1'b1;
            addr_d  = victim_addr;
            line_d  = data_q[idx];
          end else begin
            state_d = ALLOC;
            addr_d  = fill_addr;
          end
        end
      end
      WB: begin
        en_d = 1'b1;
        if (mem_ack_i) begin
          state_d = ALLOC;
          addr_d  = fill_addr;
        end else begin
          wr_d   = 1'b1;
          addr_d = mem_addr_o;
          line_d = mem_data_o;
        end
      end
      ALLOC: begin
        if (mem_ack_i) begin
          state_d = FILL;
        end else begin
          en_d   = 1'b1;
          addr_d = mem_addr_o;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_o <= en_d;
      mem_write_o  <= wr_d;
      mem_addr_o   <= addr_d;
      mem_data_o   <= line_d;
      if (fill_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_we) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= mem_data_i;
    end else if (store_we) begin
      data_q[idx][word_lsb +: WORD_BITS] <= cpu_data_i;
    end
  end

endmodule
